// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the 8051 fetch sequencer: code ROM port, IR strobes,
// execute handshake and branch inputs. The sequencer is the master.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 16
);
  logic                enable;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [7:0]          rom_byte;
  logic [1:0]          instr_len;
  logic                ir_load_high;
  logic                ir_load_low;
  logic [7:0]          operand3;
  logic [1:0]          len_q;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_valid;
  logic                exec_done;
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_target;
  logic                busy;

  modport master (
    input  enable, rom_byte, instr_len, exec_done, pc_load, pc_target,
    output rom_addr, ir_load_high, ir_load_low, operand3, len_q, pc,
           instr_valid, busy
  );

  modport slave (
    output enable, rom_byte, instr_len, exec_done, pc_load, pc_target,
    input  rom_addr, ir_load_high, ir_load_low, operand3, len_q, pc,
           instr_valid, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 8051 core: owns the PC, walks the code
// ROM one byte per request/latch pair and hands complete instructions to execute.
module fetch_sequencer #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    OP_REQ,
    OP_LAT,
    B2_REQ,
    B2_LAT,
    B3_REQ,
    B3_LAT,
    ISSUE
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]          len_reg, len_d;
  logic [7:0]          operand3_q, operand3_d;
  logic [1:0]          decoded_len;
  logic                load_high, load_low, valid;

  assign decoded_len = (bus.instr_len == 2'd0) ? 2'd1 : bus.instr_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      rom_addr_q <= RESET_VECTOR;
      len_reg    <= 2'd0;
      operand3_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      len_reg    <= len_d;
      operand3_q <= operand3_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_reg;
    operand3_d = operand3_q;
    load_high  = 1'b0;
    load_low   = 1'b0;
    valid      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = OP_REQ;
      end
      OP_REQ: state_d = OP_LAT;
      OP_LAT: begin
        load_high = 1'b1;
        len_d     = decoded_len;
        pc_d      = pc_q + 1'b1;
        state_d   = (decoded_len == 2'd1) ? ISSUE : B2_REQ;
      end
      B2_REQ: state_d = B2_LAT;
      B2_LAT: begin
        load_low = 1'b1;
        pc_d     = pc_q + 1'b1;
        state_d  = (len_reg == 2'd3) ? B3_REQ : ISSUE;
      end
      B3_REQ: state_d = B3_LAT;
      B3_LAT: begin
        operand3_d = bus.rom_byte;
        pc_d       = pc_q + 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        valid = 1'b1;
        if (bus.exec_done) begin
          if (bus.pc_load) pc_d = bus.pc_target;
          state_d = bus.enable ? OP_REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The address is registered on entry to each request state so the ROM
  // sees it for the whole REQ cycle and returns the byte in the LAT cycle.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (state_d == OP_REQ || state_d == B2_REQ || state_d == B3_REQ) begin
      rom_addr_d = pc_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.pc           = pc_q;
  assign bus.len_q        = len_reg;
  assign bus.operand3     = operand3_q;
  assign bus.ir_load_high = load_high;
  assign bus.ir_load_low  = load_low;
  assign bus.instr_valid  = valid;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 8051 core.
- Drives the program counter onto the code-ROM address bus and sequences ir_load_high / ir_load_low into the instruction register.
- Captures a third instruction byte locally, then presents the complete instruction to the execute unit with a valid/done handshake.
- Sits between code ROM, instruction register and execute/decode unit; owns the PC.

Parameters:
- PC_WIDTH, 16, width of program counter and ROM address.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- enable  input  1  allow new fetches; low = stop after current instruction.
- rom_addr  output  PC_WIDTH  code ROM address (registered).
- rom_byte  input  8  ROM data; valid the cycle after rom_addr is presented.
- instr_len  input  2  length from external opcode decoder, combinational on rom_byte; 0 treated as 1.
- ir_load_high  output  1  IR opcode byte load strobe.
- ir_load_low  output  1  IR second-byte load strobe.
- operand3  output  8  third instruction byte (valid when instr_valid and len_q==3).
- len_q  output  2  registered length of current instruction (1..3).
- pc  output  PC_WIDTH  address of next sequential instruction.
- instr_valid  output  1  instruction complete, awaiting execute.
- exec_done  input  1  execute unit finished; honoured only while instr_valid.
- pc_load  input  1  branch taken; honoured only with exec_done in ISSUE.
- pc_target  input  PC_WIDTH  branch destination.
- busy  output  1  FSM not in IDLE.

Behaviour:
- States: IDLE, OP_REQ, OP_LAT, B2_REQ, B2_LAT, B3_REQ, B3_LAT, ISSUE.
- Reset: state=IDLE; pc=rom_addr=RESET_VECTOR; operand3=0; len_q=0; all strobes, instr_valid and busy = 0. Reset overrides every other input in any state, including mid-instruction. The IR clears itself on the same reset.
- IDLE: if enable, go to OP_REQ; else stay.
- OP_REQ: rom_addr = pc; go to OP_LAT.
- OP_LAT:
  - Assert ir_load_high for exactly this cycle; opcode is captured into IR at the closing edge.
  - Sample instr_len into len_q, mapping 0 to 1; pc <= pc+1.
  - Next state: len 1 -> ISSUE; len 2 or 3 -> B2_REQ.
- B2_REQ: rom_addr = pc; go to B2_LAT.
- B2_LAT:
  - Assert ir_load_low for this cycle; pc <= pc+1.
  - Next state: len_q==3 -> B3_REQ; else -> ISSUE.
- B3_REQ: rom_addr = pc; go to B3_LAT.
- B3_LAT: operand3 <= rom_byte; pc <= pc+1; go to ISSUE.
- ISSUE:
  - instr_valid=1, held until exec_done.
  - On exec_done: if pc_load, pc <= pc_target; else pc unchanged.
  - Next state: enable -> OP_REQ; else -> IDLE.
  - exec_done may arrive in the first ISSUE cycle.
- Strobes:
  - ir_load_high and ir_load_low are one-hot, never asserted together, and each is asserted only in its LAT state.
  - For a 1-byte instruction the IR low byte is stale (undefined content).
- Ignored inputs: exec_done and pc_load outside ISSUE are ignored; pc_load without exec_done is ignored.
- enable low mid-fetch: the current instruction completes through ISSUE; the FSM then goes to IDLE.
- PC arithmetic: modulo 2^PC_WIDTH; FFFF+1 = 0000, including wrap inside a multi-byte instruction.
- Latency: opcode address to instr_valid = 3 / 5 / 7 cycles for length 1 / 2 / 3; zero bubble between ISSUE exit and next OP_REQ.
- busy = (state != IDLE).
- Registers: outputs are registered except instr_valid, strobes and busy, which are state decodes.

Test Plan:
- Reset then enable=1 -> cycle 1 rom_addr=0000 (OP_REQ); cycle 2 ir_load_high=1 with rom_byte=04, instr_len=1; cycle 3 instr_valid=1, pc=0001, len_q=1.
- 3-byte LJMP at 0000: bytes 02,12,34, instr_len=3 -> ir_load_high then ir_load_low on respective LAT cycles; operand3=34; pc=0003 in ISSUE. exec_done with pc_load=1, pc_target=1234 -> next rom_addr=1234.
- instr_valid held 4 cycles with exec_done=0; pc_load=1 pulsed while exec_done=0 -> ignored. exec_done then releases ISSUE with pc unchanged=0002 (2-byte instruction).
- pc=FFFF, 2-byte instruction -> byte 2 fetched from 0000; pc=0001 in ISSUE.
- enable dropped during B2_LAT -> instruction finishes, instr_valid asserted; after exec_done FSM in IDLE, busy=0, no further strobes.
- reset asserted during B3_REQ -> next cycle state IDLE, rom_addr=0000, operand3=00, instr_valid=0, no strobes.
